hni_rxrsp_q: RTL and testbench
==============================

// Module: hni_rxrsp_q
// PURPOSE
// - Response queue between the HN-I RXRSP link stage (hni_rxrsp) and hni_mshr.
// - Buffers incoming RSP flits, drops RespLCrdReturn, and decodes opcode/TxnID.
// - Presents entries to the MSHR with a valid/ready handshake.
// - Drives the credit-enable for the RXRSP stage, so link credits are issued only when an entry is guaranteed free.
// PARAMETERS
// - DEPTH      4  queue entries; power of 2, 2..16.
// - PTR_W      2  log2(DEPTH).
// - CNT_W      3  log2(DEPTH)+1; width of the occupancy and credit counters.
// PORTS
// - clk                 in   1    clock.
// - rst                 in   1    reset; asynchronous, active-high.
// - rxrsp_valid_s0      in   1    flit valid from hni_rxrsp.
// - rxrspflit_s0        in   RSP  flit (`CHIE_RSP_FLIT_RANGE).
// - rxrsp_lcrdv         in   1    credit issued to the XP this cycle (from hni_rxrsp).
// - rxrsp_crd_enable    out  1    allow hni_rxrsp to issue one more credit.
// - mshr_rsp_valid      out  1    head entry valid.
// - mshr_rsp_ready      in   1    MSHR accepts the head entry.
// - mshr_rsp_flit       out  RSP  head flit.
// - mshr_rsp_opcode     out  `CHIE_RSP_FLIT_OPCODE_RANGE   head opcode.
// - mshr_rsp_txnid      out  `CHIE_RSP_FLIT_TXNID_RANGE    head TxnID.
// - rxrsp_q_overflow    out  1    sticky error: a flit arrived while the queue was full.
// BEHAVIOUR
// - Reset values: all outputs 0; wr_ptr, rd_ptr, occ_cnt and crd_out_cnt = 0.
//   The rxrsp_crd_enable output is 1 after the first clk (its register resets to 0).
// - Enqueue
//   - Condition: rxrsp_valid_s0 & opcode!=RespLCrdReturn (4'h0) & occ_cnt<DEPTH.
//   - Action: write the flit at wr_ptr; wr_ptr wraps modulo DEPTH.
//   - RespLCrdReturn is consumed silently: no enqueue, but it still returns a credit (crd_out_cnt decrements).
// - Dequeue
//   - Condition: mshr_rsp_valid & mshr_rsp_ready.
//   - Action: rd_ptr wraps modulo DEPTH.
//   - Outputs are driven from the entry at rd_ptr.
//   - mshr_rsp_valid = (occ_cnt!=0).
// - Simultaneous enqueue and dequeue: occ_cnt unchanged; allowed when full, because the dequeue frees the slot in the same cycle.
// - Latency: a flit accepted in cycle N gives mshr_rsp_valid in cycle N+1.
// - Head stability: the head outputs stay stable while valid & !ready.
// - Overflow
//   - Condition: enqueue condition fails only because occ_cnt==DEPTH and there is no same-cycle dequeue.
//   - Action: the flit is dropped and rxrsp_q_overflow is set; it clears only on rst.
// - Credit accounting
//   - crd_out_cnt counts credits outstanding at the XP: +1 on rxrsp_lcrdv, -1 on rxrsp_valid_s0.
//   - Both in the same cycle: no change.
//   - crd_out_cnt saturates at 0 and at DEPTH.
// - Credit enable
//   - rxrsp_crd_enable is registered:
//     next = (DEPTH - occ_cnt_nxt) > (crd_out_cnt_nxt + rxrsp_crd_enable_q).
//   - The +enable_q term reserves room for the credit that hni_rxrsp issues one cycle after the enable.
//   - Invariant: occ_cnt + crd_out_cnt <= DEPTH at all times.
// - Counter arithmetic: all counters are CNT_W bits unsigned; comparisons are done in CNT_W+1 bits to avoid wrap.
// - Reset mid-operation: queue contents are discarded, valid drops immediately (async), and counters clear.
// CONFIGURATION
// - HNI_RXRSP_Q_BYPASS_EN defined
//   - Condition: queue empty, enqueue valid and mshr_rsp_ready=1.
//   - The flit is driven combinationally to the mshr_rsp_* outputs in the same cycle with mshr_rsp_valid=1.
//   - It is not written, and pointers and occ_cnt are unchanged (zero latency).
// - HNI_RXRSP_Q_BYPASS_EN undefined
//   - mshr_rsp_* are driven only from storage, with a fixed 1-cycle latency.
//   - No combinational path from rxrsp_* to mshr_rsp_*.
// TESTING
// - T1: reset, then 4 rxrsp_lcrdv pulses.
//   -> crd_out_cnt=4; rxrsp_crd_enable=0 from the cycle after the 4th enable.
// - T2: DEPTH=4, mshr_rsp_ready=0, 4 CompAck flits with TxnID 1..4.
//   -> occ_cnt=4; the head keeps TxnID=1 stable.
//   -> Then ready=1 for 4 cycles: TxnIDs 1,2,3,4 in order and valid=0 afterwards.
// - T3: queue full and a 5th flit with ready=0.
//   -> flit dropped, rxrsp_q_overflow=1 and it stays 1.
//   -> The same case with ready=1 in that cycle: no overflow and occ_cnt stays 4.
// - T4: RespLCrdReturn flit with crd_out_cnt=2.
//   -> not enqueued (valid stays 0), crd_out_cnt=1.
// - T5: 6 enqueue/dequeue pairs.
//   -> pointers wrap past DEPTH-1 and data order is preserved.
// - T6: rst asserted with occ_cnt=3.
//   -> mshr_rsp_valid=0 asynchronously and all counters are 0 after reset.
//   -> Bypass build only: empty queue, ready=1, flit TxnID=7 -> mshr_rsp_valid=1 with TxnID=7 in the same cycle, occ_cnt=0.

Source files
------------

// File: rtl/hni_rxrsp_q.sv
// HN-I RXRSP response queue: buffers RSP flits for hni_mshr, drops RespLCrdReturn, gates link credits.
// Optional same-cycle bypass to the MSHR when empty: define HNI_RXRSP_Q_BYPASS_EN.
`ifndef CHIE_RSP_FLIT_RANGE
`define CHIE_RSP_FLIT_RANGE 39:0
`endif
`ifndef CHIE_RSP_FLIT_OPCODE_RANGE
`define CHIE_RSP_FLIT_OPCODE_RANGE 15:12
`endif
`ifndef CHIE_RSP_FLIT_TXNID_RANGE
`define CHIE_RSP_FLIT_TXNID_RANGE 11:0
`endif

module hni_rxrsp_q #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter int unsigned CNT_W = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rxrsp_valid_s0,
  input  logic [`CHIE_RSP_FLIT_RANGE]         rxrspflit_s0,
  input  logic                                rxrsp_lcrdv,
  output logic                                rxrsp_crd_enable,
  output logic                                mshr_rsp_valid,
  input  logic                                mshr_rsp_ready,
  output logic [`CHIE_RSP_FLIT_RANGE]         mshr_rsp_flit,
  output logic [`CHIE_RSP_FLIT_OPCODE_RANGE]  mshr_rsp_opcode,
  output logic [`CHIE_RSP_FLIT_TXNID_RANGE]   mshr_rsp_txnid,
  output logic                                rxrsp_q_overflow
);

  typedef logic [`CHIE_RSP_FLIT_RANGE]        flit_t;
  typedef logic [`CHIE_RSP_FLIT_OPCODE_RANGE] opc_t;

  localparam opc_t            OPC_LCRD_RETURN = '0;
  localparam logic [CNT_W:0]  DEPTH_X         = (CNT_W+1)'(DEPTH);

  flit_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_cnt_q, occ_cnt_d;
  logic [CNT_W-1:0] crd_out_cnt_q, crd_out_cnt_d;
  logic             crd_en_q, crd_en_d;
  logic             ovf_q, ovf_d;

  logic             is_rsp, stored_valid, full, deq, enq, bypass;
  logic [CNT_W:0]   occ_x, crd_x;
  flit_t            head;

  always_comb begin
    is_rsp       = rxrsp_valid_s0 && (opc_t'(rxrspflit_s0[`CHIE_RSP_FLIT_OPCODE_RANGE]) != OPC_LCRD_RETURN);
    stored_valid = (occ_cnt_q != '0);
    full         = ({1'b0, occ_cnt_q} == DEPTH_X);
    deq          = stored_valid && mshr_rsp_ready;
`ifdef HNI_RXRSP_Q_BYPASS_EN
    bypass       = !stored_valid && is_rsp && mshr_rsp_ready;
`else
    bypass       = 1'b0;
`endif
    // a full queue still accepts when the head leaves in the same cycle
    enq          = is_rsp && !bypass && (!full || deq);
  end

  always_comb begin
    wr_ptr_d = enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = deq ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    occ_x = {1'b0, occ_cnt_q};
    if (enq && !deq)      occ_x = occ_x + (CNT_W+1)'(1);
    else if (!enq && deq) occ_x = occ_x - (CNT_W+1)'(1);
    occ_cnt_d = occ_x[CNT_W-1:0];

    crd_x = {1'b0, crd_out_cnt_q};
    if (rxrsp_lcrdv && !rxrsp_valid_s0 && (crd_x != DEPTH_X))
      crd_x = crd_x + (CNT_W+1)'(1);
    else if (!rxrsp_lcrdv && rxrsp_valid_s0 && (crd_x != '0))
      crd_x = crd_x - (CNT_W+1)'(1);
    crd_out_cnt_d = crd_x[CNT_W-1:0];

    // the enable_q term holds back the credit hni_rxrsp may issue next cycle
    crd_en_d = (DEPTH_X - occ_x) > (crd_x + {{CNT_W{1'b0}}, crd_en_q});
    ovf_d    = ovf_q || (is_rsp && full && !deq);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_cnt_q     <= '0;
      crd_out_cnt_q <= '0;
      crd_en_q      <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_cnt_q     <= occ_cnt_d;
      crd_out_cnt_q <= crd_out_cnt_d;
      crd_en_q      <= crd_en_d;
      ovf_q         <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= rxrspflit_s0;
  end

  always_comb begin
    head = stored_valid ? mem_q[rd_ptr_q] : '0;
`ifdef HNI_RXRSP_Q_BYPASS_EN
    mshr_rsp_valid = stored_valid || bypass;
    mshr_rsp_flit  = bypass ? rxrspflit_s0 : head;
`else
    mshr_rsp_valid = stored_valid;
    mshr_rsp_flit  = head;
`endif
    mshr_rsp_opcode  = mshr_rsp_flit[`CHIE_RSP_FLIT_OPCODE_RANGE];
    mshr_rsp_txnid   = mshr_rsp_flit[`CHIE_RSP_FLIT_TXNID_RANGE];
    rxrsp_crd_enable = crd_en_q;
    rxrsp_q_overflow = ovf_q;
  end

endmodule

// File: tb/tb_hni_rxrsp_q.sv
// Scoreboard bench for hni_rxrsp_q: directed scenarios plus randomized credit-compliant traffic.
`ifndef CHIE_RSP_FLIT_RANGE
`define CHIE_RSP_FLIT_RANGE 39:0
`endif
`ifndef CHIE_RSP_FLIT_OPCODE_RANGE
`define CHIE_RSP_FLIT_OPCODE_RANGE 15:12
`endif
`ifndef CHIE_RSP_FLIT_TXNID_RANGE
`define CHIE_RSP_FLIT_TXNID_RANGE 11:0
`endif

module tb_hni_rxrsp_q;
  localparam int DEPTH = 4;
  typedef logic [`CHIE_RSP_FLIT_RANGE]        flit_t;
  typedef logic [`CHIE_RSP_FLIT_OPCODE_RANGE] opc_t;
  typedef logic [`CHIE_RSP_FLIT_TXNID_RANGE]  txn_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  rxrsp_valid_s0 = 1'b0;
  flit_t rxrspflit_s0 = '0;
  logic  rxrsp_lcrdv = 1'b0;
  logic  rxrsp_crd_enable;
  logic  mshr_rsp_valid;
  logic  mshr_rsp_ready = 1'b0;
  flit_t mshr_rsp_flit;
  opc_t  mshr_rsp_opcode;
  txn_t  mshr_rsp_txnid;
  logic  rxrsp_q_overflow;

  hni_rxrsp_q #(.DEPTH(4), .PTR_W(2), .CNT_W(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .rxrsp_valid_s0   (rxrsp_valid_s0),
    .rxrspflit_s0     (rxrspflit_s0),
    .rxrsp_lcrdv      (rxrsp_lcrdv),
    .rxrsp_crd_enable (rxrsp_crd_enable),
    .mshr_rsp_valid   (mshr_rsp_valid),
    .mshr_rsp_ready   (mshr_rsp_ready),
    .mshr_rsp_flit    (mshr_rsp_flit),
    .mshr_rsp_opcode  (mshr_rsp_opcode),
    .mshr_rsp_txnid   (mshr_rsp_txnid),
    .rxrsp_q_overflow (rxrsp_q_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: queue contents as a list, counters as plain integers
  flit_t sb_q[$];
  int    m_occ = 0;
  int    m_crd = 0;
  bit    m_en  = 1'b0;
  bit    m_ovf = 1'b0;
  bit    exp_valid, exp_en, exp_ovf;
  bit    mon_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic flit_t mk(input opc_t opc, input txn_t txn);
    logic [63:0] r;
    flit_t f;
    r = {$urandom(), $urandom()};
    f = r[$bits(flit_t)-1:0];
    f[`CHIE_RSP_FLIT_OPCODE_RANGE] = opc;
    f[`CHIE_RSP_FLIT_TXNID_RANGE]  = txn;
    return f;
  endfunction

  // drive one cycle of inputs and advance the model over the coming edge
  task automatic drive(input bit v, input flit_t f, input bit lc, input bit rdy);
    bit is_rsp, byp, deq, enq;
    int occ_n, crd_n;
    rxrsp_valid_s0 = v;
    rxrspflit_s0   = f;
    rxrsp_lcrdv    = lc;
    mshr_rsp_ready = rdy;
    is_rsp = v && (f[`CHIE_RSP_FLIT_OPCODE_RANGE] != 4'h0);
    byp = 1'b0;
`ifdef HNI_RXRSP_Q_BYPASS_EN
    byp = (m_occ == 0) && is_rsp && rdy;
`endif
    deq = (m_occ > 0) && rdy;
    enq = is_rsp && !byp && ((m_occ < DEPTH) || deq);
    exp_valid = (m_occ > 0) || byp;
    exp_en    = m_en;
    exp_ovf   = m_ovf;
    if (enq || byp) sb_q.push_back(f);
    if (is_rsp && (m_occ == DEPTH) && !deq) m_ovf = 1'b1;
    occ_n = m_occ + int'(enq) - int'(deq);
    crd_n = m_crd + int'(lc) - int'(v);
    if (crd_n < 0) crd_n = 0;
    if (crd_n > DEPTH) crd_n = DEPTH;
    m_en  = (DEPTH - occ_n) > (crd_n + int'(m_en));
    m_occ = occ_n;
    m_crd = crd_n;
  endtask

  task automatic cyc(input bit v, input flit_t f, input bit lc, input bit rdy);
    @(negedge clk);
    #1;
    drive(v, f, lc, rdy);
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, '0, 1'b0, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"},    mshr_rsp_valid, 0);
    chk({tag, "_flit"},     mshr_rsp_flit, 0);
    chk({tag, "_crd_en"},   rxrsp_crd_enable, 0);
    chk({tag, "_overflow"}, rxrsp_q_overflow, 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    m_occ = 0; m_crd = 0; m_en = 1'b0; m_ovf = 1'b0;
    sb_q.delete();
    drive(1'b0, '0, 1'b0, 1'b0);
    mon_on = 1'b1;
  endtask

  // monitor: samples just before each rising edge
  initial begin
    flit_t e;
    forever begin
      @(negedge clk);
      #4;
      if (mon_on && !rst) begin
        chk("valid", mshr_rsp_valid, exp_valid);
        chk("crd_enable", rxrsp_crd_enable, exp_en);
        chk("overflow", rxrsp_q_overflow, exp_ovf);
        if (mshr_rsp_valid) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL head_unexpected actual=valid required=empty t=%0t", $time);
          end else begin
            e = sb_q[0];
            chk("head_flit", mshr_rsp_flit, e);
            chk("head_opcode", mshr_rsp_opcode, e[`CHIE_RSP_FLIT_OPCODE_RANGE]);
            chk("head_txnid", mshr_rsp_txnid, e[`CHIE_RSP_FLIT_TXNID_RANGE]);
            if (mshr_rsp_ready) void'(sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    release_reset();

    // T1: four credits out -> enable must drop
    repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);
    idle(1'b0);
    #2 chk("T1_crd_enable_off", rxrsp_crd_enable, 0);

    // T4: two CompAck consume credits, then RespLCrdReturn is dropped
    cyc(1'b1, mk(4'h2, 12'h0A1), 1'b0, 1'b1);
    cyc(1'b1, mk(4'h2, 12'h0A2), 1'b0, 1'b1);
    idle(1'b1);
    cyc(1'b1, mk(4'h0, 12'h0A3), 1'b0, 1'b1);
    idle(1'b1);
    #2 chk("T4_lcrd_return_not_queued", mshr_rsp_valid, 0);

    // T2: fill with TxnID 1..4, hold, then drain in order
    for (int i = 1; i <= 4; i++) cyc(1'b1, mk(4'h2, txn_t'(i)), 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    #2 chk("T2_head_txnid_held", mshr_rsp_txnid, 1);
    repeat (4) idle(1'b1);
    idle(1'b0);
    #2 chk("T2_empty_after_drain", mshr_rsp_valid, 0);

    // T3: full + dequeue accepts, full + stall overflows (sticky)
    for (int i = 11; i <= 14; i++) cyc(1'b1, mk(4'h3, txn_t'(i)), 1'b0, 1'b0);
    cyc(1'b1, mk(4'h3, 12'd15), 1'b0, 1'b1);
    idle(1'b0);
    #2 chk("T3_no_overflow_with_deq", rxrsp_q_overflow, 0);
    cyc(1'b1, mk(4'h3, 12'd16), 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    #2 chk("T3_overflow_sticky", rxrsp_q_overflow, 1);
    repeat (5) idle(1'b1);

    // T5: six back-to-back enqueue/dequeue pairs across the pointer wrap
    for (int i = 0; i < 6; i++) cyc(1'b1, mk(4'h5, txn_t'(32 + i)), 1'b0, 1'b1);
    repeat (2) idle(1'b1);

    // T6: asynchronous reset with three entries held
    for (int i = 0; i < 3; i++) cyc(1'b1, mk(4'h2, txn_t'(48 + i)), 1'b0, 1'b0);
    @(negedge clk);
    #1 chk("T6_valid_before_rst", mshr_rsp_valid, 1);
    mon_on = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_outputs("T6_async");
    release_reset();
    idle(1'b0);
    #2 chk("T6_crd_enable_after_rst", rxrsp_crd_enable, 1);

`ifdef HNI_RXRSP_Q_BYPASS_EN
    cyc(1'b1, mk(4'h2, 12'd7), 1'b0, 1'b1);
    #2 chk("T6_bypass_valid", mshr_rsp_valid, 1);
    chk("T6_bypass_txnid", mshr_rsp_txnid, 7);
    idle(1'b1);
    #2 chk("T6_bypass_not_stored", mshr_rsp_valid, 0);
`endif

    // randomized traffic obeying the credit protocol
    for (int i = 0; i < 400; i++) begin
      bit lc, v, rdy;
      opc_t op;
      lc  = m_en && ($urandom_range(0, 3) != 0);
      v   = (m_crd > 0) && ($urandom_range(0, 2) != 0);
      op  = ($urandom_range(0, 7) == 0) ? 4'h0 : opc_t'($urandom_range(1, 15));
      rdy = ($urandom_range(0, 1) == 1);
      cyc(v, mk(op, txn_t'($urandom())), lc, rdy);
    end
    chk("rand_no_overflow", rxrsp_q_overflow, 0);

    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    @(negedge clk);
    mon_on = 1'b0;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
